// File: rtl/spm_stream.sv
`default_nettype none
// ============================================================================
// Module   : spm_stream
// Brief    : Serial-parallel multiplier; parallel operand a, serial x in,
//            serial 2*BITS-bit product out, LSB first, signed or unsigned.
// Revision : 1.0  initial release
// ============================================================================
module spm_stream #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_mode,
    input  logic [BITS-1:0] a,
    input  logic            x,
    input  logic            x_valid,
    output logic            x_ready,
    input  logic            abort,
    output logic            y,
    output logic            y_valid,
    output logic            y_last,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(BITS) + 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [BITS-1:0] r_a;
    logic [BITS-1:0] r_sum;
    logic [BITS-1:0] r_carry;
    logic [BITS-1:0] r_xsr;
    logic            r_signed;
    logic            r_xmsb;
    logic            r_borrow;
    logic            r_y;
    logic            r_y_valid;
    logic            r_y_last;
    logic            r_done;

    logic            w_start;
    logic            w_step;
    logic            w_cnt_last;
    logic            w_xbit;
    logic [BITS-1:0] w_sout;
    logic [BITS-1:0] w_cout;
    logic            w_sub;
    logic            w_diff;
    logic            w_bout;

    assign w_start    = (r_state == S_IDLE) && start;
    assign w_step     = ((r_state == S_SHIFT) && x_valid && !abort) ||
                        ((r_state == S_FLUSH) && !abort);
    assign w_cnt_last = (r_cnt == C_CNT_LAST);
    assign w_xbit     = (r_state == S_SHIFT) ? x : (r_signed & r_xmsb);

    // Carry-save cells: sums shift one place down per step, carries stay put.
    for (genvar i = 0; i < BITS; i++) begin : g_cell
        logic w_pp;
        assign w_pp      = r_a[i] & w_xbit;
        assign w_sout[i] = w_pp ^ r_sum[i] ^ r_carry[i];
        assign w_cout[i] = (w_pp & r_sum[i]) | (w_pp & r_carry[i]) | (r_sum[i] & r_carry[i]);
    end

    // Cells treat a as unsigned; a negative a needs a_msb * x * 2^BITS removed,
    // which is a serial subtraction of the stored x bits during FLUSH.
    assign w_sub  = (r_state == S_FLUSH) & r_signed & r_a[BITS-1] & r_xsr[0];
    assign w_diff = w_sout[0] ^ w_sub ^ r_borrow;
    assign w_bout = (~w_sout[0] & (w_sub | r_borrow)) | (w_sub & r_borrow);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        x_ready = 1'b0;
        busy    = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                x_ready = 1'b1;
                if (abort)                       w_next = S_IDLE;
                else if (x_valid && w_cnt_last)  w_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (abort || w_cnt_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_sum    <= '0;
            r_carry  <= '0;
            r_xsr    <= '0;
            r_signed <= 1'b0;
            r_xmsb   <= 1'b0;
            r_borrow <= 1'b0;
        end else if (w_start) begin
            r_cnt    <= '0;
            r_a      <= a;
            r_sum    <= '0;
            r_carry  <= '0;
            r_xsr    <= '0;
            r_signed <= signed_mode;
            r_xmsb   <= 1'b0;
            r_borrow <= 1'b0;
        end else if (w_step) begin
            r_cnt    <= w_cnt_last ? '0 : r_cnt + CW'(1);
            r_sum    <= {1'b0, w_sout[BITS-1:1]};
            r_carry  <= w_cout;
            r_borrow <= w_bout;
            if (r_state == S_SHIFT) begin
                r_xsr  <= {x, r_xsr[BITS-1:1]};
                r_xmsb <= x;
            end else begin
                r_xsr  <= {1'b0, r_xsr[BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_y       <= 1'b0;
            r_y_valid <= 1'b0;
            r_y_last  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_y       <= w_step & w_diff;
            r_y_valid <= w_step;
            r_y_last  <= w_step & (r_state == S_FLUSH) & w_cnt_last;
            r_done    <= w_step & (r_state == S_FLUSH) & w_cnt_last;
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign y_last  = r_y_last;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spm_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_spm_stream
// Brief    : Table-driven check of spm_stream at BITS=8 plus abort/reset runs.
// Revision : 1.0  initial release
// ============================================================================
module tb_spm_stream;

    localparam int BITS = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            signed_mode;
    logic [BITS-1:0] a;
    logic            x;
    logic            x_valid;
    logic            x_ready;
    logic            abort;
    logic            y;
    logic            y_valid;
    logic            y_last;
    logic            busy;
    logic            done;

    spm_stream #(.BITS(BITS)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .x(x), .x_valid(x_valid), .x_ready(x_ready), .abort(abort),
        .y(y), .y_valid(y_valid), .y_last(y_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  av;
        logic [7:0]  xv;
        logic        sg;
        int          stall;
        logic        glitch;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl [10];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] got;
    int          nbits;
    logic        last_ok;
    logic        stray;
    logic        done_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr_collect();
        got = '0; nbits = 0; last_ok = 1'b0; stray = 1'b0; done_seen = 1'b0;
    endtask

    // Advance one clock, then record whatever product bit the DUT presents.
    task automatic tick_c();
        @(posedge clk);
        #1;
        if (y_valid) begin
            if (nbits < 16) begin
                got[nbits] = y;
                if (nbits == 15) last_ok = y_last & done & ~busy;
                else if (y_last | done) stray = 1'b1;
            end else begin
                stray = 1'b1;
            end
            nbits++;
        end else if (y_last | done | y) begin
            stray = 1'b1;
        end
        if (done) done_seen = 1'b1;
    endtask

    task automatic run_op(input vec_t v, input string nm);
        clr_collect();
        start = 1'b1; a = v.av; signed_mode = v.sg; x_valid = 1'b0;
        tick_c();
        start = 1'b0;
        chk({nm, " busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < BITS; i++) begin
            for (int s = 0; s < v.stall; s++) begin
                x_valid = 1'b0; x = $urandom_range(0, 1);
                chk({nm, " x_ready stall"}, {31'd0, x_ready}, 32'd1);
                tick_c();
                if (s > 0) chk({nm, " y_valid stall"}, {31'd0, y_valid}, 32'd0);
            end
            x = v.xv[i]; x_valid = 1'b1;
            if (v.glitch && i == 3) begin
                start = 1'b1; a = ~v.av; signed_mode = ~v.sg;
            end
            chk({nm, " x_ready"}, {31'd0, x_ready}, 32'd1);
            tick_c();
            start = 1'b0; a = v.av; signed_mode = v.sg;
        end
        x_valid = 1'b0; x = 1'b0;
        for (int t = 0; t < 40 && !done_seen; t++) tick_c();
        chk({nm, " done seen"}, {31'd0, done_seen}, 32'd1);
        chk({nm, " product"}, {16'd0, got}, {16'd0, v.exp});
        chk({nm, " bit count"}, nbits, 32'd16);
        chk({nm, " last/done/busy"}, {31'd0, last_ok}, 32'd1);
        chk({nm, " stray pulse"}, {31'd0, stray}, 32'd0);
    endtask

    initial begin
        tbl[0] = '{8'hFF, 8'hFF, 1'b0, 0, 1'b0, 16'hFE01};
        tbl[1] = '{8'h80, 8'h80, 1'b1, 0, 1'b0, 16'h4000};
        tbl[2] = '{8'h03, 8'hFB, 1'b1, 0, 1'b0, 16'hFFF1};
        tbl[3] = '{8'h0D, 8'h0B, 1'b0, 3, 1'b0, 16'h008F};
        tbl[4] = '{8'h07, 8'h09, 1'b0, 0, 1'b0, 16'h003F};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 0, 1'b0, 16'h0001};
        tbl[6] = '{8'h80, 8'h7F, 1'b1, 1, 1'b0, 16'hC080};
        tbl[7] = '{8'h00, 8'hAB, 1'b0, 0, 1'b0, 16'h0000};
        tbl[8] = '{8'h12, 8'h34, 1'b0, 0, 1'b1, 16'h03A8};
        tbl[9] = '{8'h7F, 8'h80, 1'b1, 0, 1'b1, 16'hC080};

        rst = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0;
        x = 1'b0; x_valid = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {26'd0, x_ready, y, y_valid, y_last, busy, done}, 32'd0);
        rst = 1'b1;

        // Abort while idle does nothing.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle abort busy", {31'd0, busy}, 32'd0);

        // Table entries; the pairs 0->1 and 1->2 start on the done cycle.
        for (int k = 0; k < 10; k++) begin
            run_op(tbl[k], $sformatf("vec%0d", k));
            if (k >= 2) repeat (2) @(posedge clk);
            #1;
        end

        // Abort after 5 accepted x bits.
        clr_collect();
        start = 1'b1; a = 8'h55; signed_mode = 1'b0;
        tick_c();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x = 1'b1; x_valid = 1'b1;
            tick_c();
        end
        abort = 1'b1;
        tick_c();
        abort = 1'b0; x_valid = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort y_valid", {31'd0, y_valid}, 32'd0);
        repeat (12) tick_c();
        chk("abort bits", nbits, 32'd5);
        chk("abort no done", {31'd0, done_seen}, 32'd0);
        run_op('{8'h0D, 8'h0B, 1'b0, 0, 1'b0, 16'h008F}, "post-abort");

        // Reset pulse in the middle of FLUSH.
        clr_collect();
        start = 1'b1; a = 8'hFF; signed_mode = 1'b1;
        tick_c();
        start = 1'b0;
        for (int i = 0; i < BITS; i++) begin
            x = 1'b1; x_valid = 1'b1;
            tick_c();
        end
        x_valid = 1'b0;
        repeat (3) tick_c();
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst mid-flush outputs", {26'd0, x_ready, y, y_valid, y_last, busy, done}, 32'd0);
        rst = 1'b1;
        clr_collect();
        repeat (12) tick_c();
        chk("rst no done", {31'd0, done_seen}, 32'd0);
        run_op('{8'h07, 8'h09, 1'b0, 0, 1'b0, 16'h003F}, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spm_stream.md
SPM_STREAM -- requirements
Module: spm_stream

Interface
REQ-001 SHALL have parameter BITS, default 32, operand width; legal range 2..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request new multiply; sampled only while busy=0.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-006 SHALL have port a  input  BITS  parallel multiplier operand; captured with start.
REQ-007 SHALL have port x  input  1  serial multiplicand bit, LSB first.
REQ-008 SHALL have port x_valid  input  1  x carries a valid bit this cycle.
REQ-009 SHALL have port x_ready  output  1  block accepts an x bit this cycle.
REQ-010 SHALL have port abort  input  1  cancel current operation.
REQ-011 SHALL have port y  output  1  serial product bit, LSB first.
REQ-012 SHALL have port y_valid  output  1  y holds a product bit this cycle.
REQ-013 SHALL have port y_last  output  1  marks product bit 2*BITS-1.
REQ-014 SHALL have port busy  output  1  operation in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, FLUSH; busy = (state != IDLE).
REQ-017 IDLE: start=1 SHALL capture a, signed_mode, clear all partial-sum/carry state and the step counter, and go to SHIFT next cycle.
REQ-018 SHIFT: x_ready SHALL be 1; a step occurs only when x_valid=1; x_valid=0 SHALL freeze all datapath state (stall, unlimited length).
REQ-019 After BITS accepted x bits the FSM SHALL enter FLUSH; x_ready=0 in FLUSH and IDLE.
REQ-020 FLUSH SHALL step every cycle for exactly BITS steps, feeding x's captured MSB (signed_mode=1) or 0 (signed_mode=0) as the multiplicand bit, then return to IDLE.
REQ-021 Product P SHALL equal (x * a) mod 2^(2*BITS), with both operands sign-extended to 2*BITS when signed_mode=1, zero-extended otherwise.
REQ-022 Step k (k = 0..2*BITS-1) SHALL present P[k] on y with y_valid=1 in the cycle after step k; y_valid=0 in all other cycles; y holds 0 when y_valid=0.
REQ-023 y_last and done SHALL both be 1 exactly in the cycle y carries P[2*BITS-1]; that cycle state is already IDLE (busy=0).
REQ-024 start SHALL be accepted in the cycle done=1; new operation outputs SHALL not overlap the previous product.
REQ-025 start while busy=1 SHALL be ignored with no effect on operands or state.
REQ-026 abort=1 in SHIFT or FLUSH SHALL return to IDLE next cycle, force y_valid, y_last, done to 0 next cycle, and discard the partial product; abort in IDLE SHALL have no effect; abort overrides start and x_valid in the same cycle.
REQ-027 Step counter SHALL be clog2(BITS)+1 bits and SHALL not wrap within an operation.
REQ-028 Internal arithmetic SHALL be a chain of carry-saving bit cells, one x bit per step, with no 2*BITS-wide parallel adder.

Reset
REQ-029 rst=0 at a rising edge SHALL set state IDLE, clear counter, partial sums, carries and captured operands; next cycle x_ready, y, y_valid, y_last, busy, done SHALL all be 0.
REQ-030 rst=0 mid-operation SHALL discard the operation with no done pulse; rst SHALL take priority over start, abort and x_valid.

Verification
REQ-031 BITS=8, unsigned, a=0xFF, x=0xFF streamed without stall -> 16 y_valid bits forming 0xFE01, y_last/done on the 16th, busy low that cycle.
REQ-032 BITS=8, signed, a=0x80, x=0x80 -> 0x4000; a=0x03, x=0xFB -> 0xFFF1.
REQ-033 BITS=8, unsigned a=0x0D, x=0x0B with x_valid low for 3 random cycles between bits -> product 0x008F, no y_valid during stall cycles, x_ready high throughout SHIFT.
REQ-034 start pulsed during SHIFT with different a -> ignored, product matches original a; start on the done cycle -> second product correct, back-to-back.
REQ-035 abort asserted after 5 x bits -> next cycle busy=0, no done, no further y_valid; following start/multiply correct.
REQ-036 rst low for one cycle during FLUSH -> all outputs 0 next cycle, no done; subsequent operation 0x07*0x09 unsigned gives 0x003F.
